// File: rtl/uart_transmitter_if.sv
// TX buffer handshake between the UART register block and the TX engine.
// The register block side is the master; the TX engine is the slave.
interface uart_transmitter_if;
  logic [7:0] tx_data_i;   // TX buffer read data, valid the cycle after a pop
  logic       tx_empty_i;  // TX buffer empty
  logic       tx_cts_o;    // one-cycle pop strobe
  logic       tx_done_o;   // one-cycle pulse when the last stop bit ends

  modport master (
    output tx_data_i,
    output tx_empty_i,
    input  tx_cts_o,
    input  tx_done_o
  );

  modport slave (
    input  tx_data_i,
    input  tx_empty_i,
    output tx_cts_o,
    output tx_done_o
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART TX engine: pops one byte per frame from the TX buffer and serialises
// start, data (LSB first), optional parity and 1/2 stop bits at the baud rate.
module uart_transmitter #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned TICK_CNT_W = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  uart_transmitter_if.slave     tx_if,
  input  logic                  tx_enable_i,
  input  logic [1:0]            data_lenght_i,
  input  logic                  stop_bits_i,
  input  logic                  parity_enable_i,
  input  logic                  parity_mode_i,
  input  logic [TICK_CNT_W-1:0] divider_i,
  input  logic                  flow_control_i,
  input  logic                  cts_n_i,
  output logic                  uart_tx_o
);

  localparam int unsigned     OS_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t                r_state, w_state_next;
  logic                  r_cts_meta, r_cts_sync;
  logic [TICK_CNT_W-1:0] r_tick_cnt;
  logic [OS_W-1:0]       r_os_cnt;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_shift, w_shift_next;
  logic [1:0]            r_len;
  logic                  r_stop, r_par_en, r_parity;
  logic [TICK_CNT_W-1:0] r_div;
  logic                  r_tx, w_tx_next;
  logic                  r_done, w_done_next;
  logic                  w_running, w_tick, w_bit_end;
  logic                  w_last_data, w_last_stop;
  logic [7:0]            w_data_mask;
  logic                  w_parity_calc;
  logic                  w_cts;

  assign w_running   = (r_state == START) || (r_state == DATA) ||
                       (r_state == PARITY) || (r_state == STOP);
  assign w_tick      = w_running && (r_tick_cnt == r_div);
  assign w_bit_end   = w_tick && (r_os_cnt == OS_LAST);
  assign w_last_data = (r_bit_cnt == (3'd4 + {1'b0, r_len}));
  assign w_last_stop = (r_bit_cnt == {2'b00, r_stop});

  // Two-stage synchroniser for the asynchronous clear-to-send input
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
    end else begin
      r_cts_meta <= cts_n_i;
      r_cts_sync <= r_cts_meta;
    end
  end

  // Baud tick, oversample and bit counters; held at zero outside the frame
  always_ff @(posedge clk_i) begin
    if (rst_i || !w_running) begin
      r_tick_cnt <= '0;
      r_os_cnt   <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_CNT_W'(1);
      if (w_tick)
        r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_W'(1);
      if (w_bit_end)
        r_bit_cnt <= (w_state_next != r_state) ? '0 : r_bit_cnt + 3'd1;
    end
  end

  // Active data bit mask and parity of the byte being loaded
  always_comb begin
    w_data_mask = 8'hFF;
    case (data_lenght_i)
      2'b00:   w_data_mask = 8'h1F;
      2'b01:   w_data_mask = 8'h3F;
      2'b10:   w_data_mask = 8'h7F;
      default: w_data_mask = 8'hFF;
    endcase
    w_parity_calc = (^(tx_if.tx_data_i & w_data_mask)) ^ parity_mode_i;
  end

  // Per-frame configuration, latched once in LOAD
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_len    <= '0;
      r_stop   <= 1'b0;
      r_par_en <= 1'b0;
      r_parity <= 1'b0;
      r_div    <= '0;
    end else if (r_state == LOAD) begin
      r_len    <= data_lenght_i;
      r_stop   <= stop_bits_i;
      r_par_en <= parity_enable_i;
      r_parity <= w_parity_calc;
      r_div    <= divider_i;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next state, shift register and registered line/done values
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_done_next  = 1'b0;
    w_cts        = 1'b0;
    case (r_state)
      IDLE:
        if (tx_enable_i && !tx_if.tx_empty_i && (!flow_control_i || !r_cts_sync))
          w_state_next = FETCH;
      FETCH: begin
        w_cts        = 1'b1;
        w_state_next = LOAD;
      end
      LOAD: begin
        w_shift_next = tx_if.tx_data_i;
        w_state_next = START;
      end
      START:
        if (w_bit_end) w_state_next = DATA;
      DATA:
        if (w_bit_end) begin
          w_shift_next = {1'b0, r_shift[7:1]};
          if (w_last_data) w_state_next = r_par_en ? PARITY : STOP;
        end
      PARITY:
        if (w_bit_end) w_state_next = STOP;
      STOP:
        if (w_bit_end && w_last_stop) begin
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end
      default: w_state_next = IDLE;
    endcase
    // The line is registered, so it is computed from the state being entered
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      PARITY:  w_tx_next = r_parity;
      default: w_tx_next = 1'b1;
    endcase
  end

  // Shift register and output flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
    end
  end

  assign uart_tx_o       = r_tx;
  assign tx_if.tx_done_o = r_done;
  assign tx_if.tx_cts_o  = w_cts;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter.
module tb_uart_transmitter;
  logic        clk = 1'b0;
  logic        rst;
  logic        tx_enable, stop_bits, par_en, par_mode, flow, cts_n;
  logic [1:0]  dlen;
  logic [14:0] div;
  logic        line;

  always #5 clk = ~clk;

  uart_transmitter_if tif();

  uart_transmitter #(.OVERSAMPLE(16), .TICK_CNT_W(15)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tx_if          (tif.slave),
    .tx_enable_i    (tx_enable),
    .data_lenght_i  (dlen),
    .stop_bits_i    (stop_bits),
    .parity_enable_i(par_en),
    .parity_mode_i  (par_mode),
    .divider_i      (div),
    .flow_control_i (flow),
    .cts_n_i        (cts_n),
    .uart_tx_o      (line)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // TX buffer model: initial block writes, monitor pops
  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cts_cnt = 0, done_cnt = 0, last_cts_cyc = 0, last_done_cyc = 0;
  int viol = 0, low_cnt = 0;

  assign tif.tx_empty_i = (rd_ptr == wr_ptr);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tif.tx_cts_o) begin
      cts_cnt++;
      last_cts_cyc = cyc;
      if (rd_ptr == wr_ptr) viol++;
      else begin
        tif.tx_data_i = mem[rd_ptr % 16];
        rd_ptr++;
      end
    end
    if (tif.tx_done_o) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (line !== 1'b1) low_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    wr_ptr++;
  endtask

  task automatic wait_cyc(input int target);
    int g = 0;
    while (cyc < target && g < 100000) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic wait_start(input string tag);
    int g = 0;
    while (line !== 1'b0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check_eq({tag, "_start_seen"}, {31'b0, line === 1'b0}, 32'd1);
  endtask

  // bits[k] is the expected line level during bit k of the frame (k=0 is start)
  task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits,
                             input int p, output int t0);
    int g;
    int dc;
    dc = done_cnt;
    wait_start(tag);
    t0 = cyc;
    for (int k = 0; k < nbits; k++) begin
      wait_cyc(t0 + k * p);
      check_eq($sformatf("%s_b%0d_first", tag, k), {31'b0, line}, {31'b0, bits[k]});
      wait_cyc(t0 + k * p + p - 1);
      check_eq($sformatf("%s_b%0d_last", tag, k), {31'b0, line}, {31'b0, bits[k]});
    end
    g = 0;
    while (done_cnt == dc && g < 4 * p) begin
      @(negedge clk);
      g++;
    end
    check_eq({tag, "_done_time"}, last_done_cyc - t0, nbits * p);
  endtask

  int t0, t1, t2, c0, d0, lo0, cc, dcyc, dd;

  initial begin
    rst = 1'b1; tx_enable = 1'b0; stop_bits = 1'b0; par_en = 1'b0; par_mode = 1'b0;
    flow = 1'b0; cts_n = 1'b1; dlen = 2'b11; div = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_line", {31'b0, line}, 32'd1);
    check_eq("rst_cts", {31'b0, tif.tx_cts_o}, 32'd0);
    check_eq("rst_done", {31'b0, tif.tx_done_o}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_line", {31'b0, line}, 32'd1);
    check_eq("idle_no_pop", cts_cnt, 0);

    // 8N1, divider 0, 0xA5
    c0 = cts_cnt; d0 = done_cnt;
    push(8'hA5);
    tx_enable = 1'b1;
    check_frame("a5", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 16, t0);
    check_eq("a5_pop_latency", t0 - last_cts_cyc, 2);
    repeat (5) @(negedge clk);
    check_eq("a5_pops", cts_cnt - c0, 1);
    check_eq("a5_dones", done_cnt - d0, 1);

    // divider 1, 7 bits, odd parity, 0x03; config changed mid-frame
    div = 15'd1; dlen = 2'b10; par_en = 1'b1; par_mode = 1'b1;
    push(8'h03);
    fork
      begin
        repeat (100) @(negedge clk);
        par_en = 1'b0; div = '0; dlen = 2'b11;
      end
    join_none
    check_frame("o7", {6'b0, 1'b1, 1'b1, 7'h03, 1'b0}, 10, 32, t0);
    repeat (5) @(negedge clk);

    // 5 bits, even parity, 2 stop bits, 0xFF then 0x11; enable drops mid-frame
    div = '0; dlen = 2'b00; stop_bits = 1'b1; par_en = 1'b1; par_mode = 1'b0;
    c0 = cts_cnt;
    push(8'hFF);
    push(8'h11);
    fork
      begin
        repeat (40) @(negedge clk);
        tx_enable = 1'b0;
      end
    join_none
    check_frame("e5", {7'b0, 2'b11, 1'b1, 5'h1F, 1'b0}, 9, 16, t0);
    repeat (50) @(negedge clk);
    check_eq("en_off_pops", cts_cnt - c0, 1);
    check_eq("en_off_line", {31'b0, line}, 32'd1);
    tx_enable = 1'b1;
    check_frame("e5b", {7'b0, 2'b11, 1'b0, 5'h11, 1'b0}, 9, 16, t0);
    repeat (5) @(negedge clk);

    // Three queued 8N1 bytes back to back
    dlen = 2'b11; stop_bits = 1'b0; par_en = 1'b0;
    c0 = cts_cnt; d0 = done_cnt;
    push(8'h55); push(8'h0F); push(8'hC3);
    check_frame("q0", {6'b0, 1'b1, 8'h55, 1'b0}, 10, 16, t0);
    dcyc = last_done_cyc;
    check_frame("q1", {6'b0, 1'b1, 8'h0F, 1'b0}, 10, 16, t1);
    check_eq("q_gap1", t1 - dcyc, 3);
    dcyc = last_done_cyc;
    check_frame("q2", {6'b0, 1'b1, 8'hC3, 1'b0}, 10, 16, t2);
    check_eq("q_gap2", t2 - dcyc, 3);
    repeat (5) @(negedge clk);
    check_eq("q_pops", cts_cnt - c0, 3);
    check_eq("q_dones", done_cnt - d0, 3);

    // Flow control: held off while cts_n high, released by cts_n low
    flow = 1'b1; cts_n = 1'b1;
    repeat (4) @(negedge clk);
    c0 = cts_cnt; d0 = done_cnt; lo0 = low_cnt;
    push(8'h3C);
    repeat (40) @(negedge clk);
    check_eq("fc_hold_pops", cts_cnt - c0, 0);
    check_eq("fc_hold_line", low_cnt - lo0, 0);
    cts_n = 1'b0;
    cc = cyc;
    fork
      begin
        repeat (60) @(negedge clk);
        cts_n = 1'b1;
      end
    join_none
    check_frame("fc", {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 16, t0);
    dd = last_cts_cyc - cc;
    check_eq("fc_fetch_latency", {31'b0, (dd >= 2 && dd <= 3)}, 32'd1);
    check_eq("fc_dones", done_cnt - d0, 1);
    flow = 1'b0;
    repeat (5) @(negedge clk);

    // Reset during DATA
    push(8'h00);
    wait_start("rs");
    repeat (40) @(negedge clk);
    check_eq("rs_in_data", {31'b0, line}, 32'd0);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rs_line", {31'b0, line}, 32'd1);
    check_eq("rs_cts", {31'b0, tif.tx_cts_o}, 32'd0);
    rst = 1'b0;
    lo0 = low_cnt;
    repeat (200) @(negedge clk);
    check_eq("rs_no_done", done_cnt - d0, 0);
    check_eq("rs_line_idle", low_cnt - lo0, 0);

    check_eq("cts_while_empty", viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
